rotary_quad_decoder: RTL and testbench
======================================

ROTARY_QUAD_DECODER -- requirements
Module: rotary_quad_decoder

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, the number of consecutive stable CLK cycles needed to accept a new input level (1 ms at 50 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer flip-flop depth per raw input (legal range 2-4).
REQ-003 SHALL have port CLK, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit, the asynchronous active-high reset.
REQ-005 SHALL have ports ROTA, ROTB and ROTCTR, inputs, 1 bit each, the raw asynchronous encoder shaft A, shaft B and push-button contacts.
REQ-006 SHALL have port STEP, output, 1 bit, a one-cycle pulse per accepted detent step.
REQ-007 SHALL have port DIR, output, 1 bit, the direction of the last step (1 = increment, 0 = decrement), valid whenever STEP=1 and held between steps.
REQ-008 SHALL have port PRESS, output, 1 bit, a one-cycle pulse on the accepted button press (0->1).
REQ-009 SHALL have port CTR_LVL, output, 1 bit, the debounced button level.
REQ-010 SHALL have port ERR, output, 1 bit, a one-cycle pulse on an illegal quadrature transition.

Function
REQ-011 SHALL pass each raw input through SYNC_STAGES flip-flops before any other use.
REQ-012 SHALL give each channel (A, B, CTR) an independent debouncer with a stable level register and a counter of width clog2(DB_CYCLES+1).
REQ-013 SHALL clear a channel's counter in any cycle where its synchronized input equals its stable level.
REQ-014 SHALL increment the counter in any cycle where the synchronized input differs from the stable level.
REQ-015 SHALL, in the cycle the counter reaches DB_CYCLES-1 with the input still differing, load the stable level from the input and clear the counter.
REQ-016 SHALL discard a glitch shorter than DB_CYCLES cycles with no output effect; the counter never wraps.
REQ-017 SHALL register the previous debounced A/B pair each cycle for edge detection.
REQ-018 SHALL, on a debounced A rise (0->1) with debounced B unchanged that cycle, assert STEP for exactly one cycle in the cycle after the stable-A update, with DIR = NOT B (B=0 -> increment).
REQ-019 SHALL treat a cycle where debounced A and B both change as illegal: assert ERR for one cycle, keep STEP at 0 and leave DIR unchanged.
REQ-020 SHALL NOT assert STEP on an A fall or on a B-only change.
REQ-021 SHALL assert PRESS for one cycle on a debounced CTR rise and never on a fall.
REQ-022 SHALL keep CTR_LVL equal to the debounced CTR stable level.
REQ-023 SHALL treat rotation and button as independent, so STEP and PRESS may assert in the same cycle.
REQ-024 SHALL give a total latency of SYNC_STAGES + DB_CYCLES + 1 cycles from a raw edge that then holds stable to the STEP or PRESS pulse.

Reset
REQ-025 SHALL, while RESET=1 (asynchronously), clear all synchronizer flops, stable levels, previous-state registers and counters to 0.
REQ-026 SHALL hold STEP=0, DIR=0, PRESS=0, CTR_LVL=0 and ERR=0 while RESET=1.
REQ-027 SHALL treat inputs at 1 after reset release as new levels that go through the full debounce; such an A or CTR rise produces STEP or PRESS normally.
REQ-028 SHALL abandon any debounce in progress at reset assertion mid-operation, and SHALL emit no pulse that is pending or cut short by reset.

Structure
REQ-029 SHALL place the default DB_CYCLES and SYNC_STAGES constants in a shared rotary package used with the downstream counter block.
REQ-030 SHALL implement the debouncer as one sub-module, rotary_debounce (synchronizer plus counter plus stable level, parameterized), instantiated three times.
REQ-031 SHALL keep edge detection, direction and error logic in the top module.

Verification
REQ-032 SHALL test a clean rise (DB_CYCLES=4, SYNC_STAGES=2, B=0, A 0->1 held): exactly one STEP with DIR=1, 7 cycles after the A edge.
REQ-033 SHALL test a glitch: A high for 3 cycles then low produces no STEP, no ERR, and a debounced A of 0.
REQ-034 SHALL test the decrement direction: B=1 held, then A 0->1 produces STEP=1 and DIR=0 for one cycle; a later A fall produces no STEP.
REQ-035 SHALL test an illegal transition: A and B both 0->1 on the same raw edge, held, produces one ERR pulse with STEP=0 and DIR unchanged.
REQ-036 SHALL test the button: CTR 0->1 held produces PRESS one cycle and CTR_LVL=1; CTR 1->0 produces no PRESS and CTR_LVL=0; a simultaneous A rise gives STEP and PRESS in the same cycle.
REQ-037 SHALL test reset mid-operation: RESET asserted 2 cycles into an A debounce gives all outputs 0 immediately, and after release with A held 1, one STEP follows 7 cycles later.

Source files
------------

// File: rtl/rotary_quad_decoder_pkg.sv
// Shared constants and helpers for the rotary encoder front end.
//   DB_CYCLES_DEF   : default debounce window in clock cycles (1 ms at 50 MHz)
//   SYNC_STAGES_DEF : default synchronizer depth per raw input
//   quad_ev_e       : event class produced by one debounced A/B update
//   quad_event()    : classifies a previous/current debounced A/B pair
package rotary_quad_decoder_pkg;

    localparam int unsigned DB_CYCLES_DEF   = 50000;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        QEV_NONE = 2'd0,
        QEV_STEP = 2'd1,
        QEV_ERR  = 2'd2
    } quad_ev_e;

    // Both channels moving in one cycle is not a legal Gray-code transition.
    // Only an A rise counts as a detent; A falls and B-only changes are silent.
    function automatic quad_ev_e quad_event(
        input logic a_prev,
        input logic b_prev,
        input logic a_now,
        input logic b_now
    );
        quad_ev_e ev;
        ev = QEV_NONE;
        if ((a_prev != a_now) && (b_prev != b_now)) begin
            ev = QEV_ERR;
        end else if (a_now && !a_prev) begin
            ev = QEV_STEP;
        end
        return ev;
    endfunction

endpackage

// File: rtl/rotary_quad_decoder_if.sv
// Signal bundle between an encoder source and the decoder.
//   rota/rotb/rotctr : raw encoder contacts (driven by master)
//   step/dir/press/ctr_lvl/err : decoder results (driven by slave)
interface rotary_quad_decoder_if;

    logic rota;
    logic rotb;
    logic rotctr;
    logic step;
    logic dir;
    logic press;
    logic ctr_lvl;
    logic err;

    modport master (
        output rota, rotb, rotctr,
        input  step, dir, press, ctr_lvl, err
    );

    modport slave (
        input  rota, rotb, rotctr,
        output step, dir, press, ctr_lvl, err
    );

endinterface

// File: rtl/rotary_debounce.sv
// Single-channel synchronizer and debouncer.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-high reset
//   din   : raw asynchronous contact
//   level : debounced stable level
// A new level is accepted after DB_CYCLES consecutive cycles of the
// synchronized input differing from the stable level.
module rotary_debounce
    import rotary_quad_decoder_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = level_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d   = '0;
        level_d = level_q;
        // Counter stops at CNT_LAST: that is the accept cycle, so it never wraps.
        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/rotary_quad_decoder.sv
// Rotary encoder decoder: debounces A, B and push-button, then turns
// debounced A rises into step pulses with direction, flags illegal
// quadrature transitions and pulses on button presses.
//   CLK     : system clock, rising edge
//   RESET   : asynchronous active-high reset
//   ROTA/ROTB/ROTCTR : raw shaft A, shaft B and button contacts
//   STEP    : one-cycle pulse per detent
//   DIR     : 1 = increment, 0 = decrement; held between steps
//   PRESS   : one-cycle pulse on button press
//   CTR_LVL : debounced button level
//   ERR     : one-cycle pulse on illegal A/B transition
module rotary_quad_decoder
    import rotary_quad_decoder_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DB_CYCLES_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ROTA,
    input  logic ROTB,
    input  logic ROTCTR,
    output logic STEP,
    output logic DIR,
    output logic PRESS,
    output logic CTR_LVL,
    output logic ERR
);

    logic a_lvl, b_lvl, c_lvl;
    logic a_prev_q, a_prev_d;
    logic b_prev_q, b_prev_d;
    logic c_prev_q, c_prev_d;
    logic step_q, step_d;
    logic dir_q, dir_d;
    logic press_q, press_d;
    logic err_q, err_d;
    quad_ev_e ev;

    rotary_debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_a (
        .clk(CLK), .rst(RESET), .din(ROTA), .level(a_lvl)
    );

    rotary_debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_b (
        .clk(CLK), .rst(RESET), .din(ROTB), .level(b_lvl)
    );

    rotary_debounce #(.DB_CYCLES(DB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_c (
        .clk(CLK), .rst(RESET), .din(ROTCTR), .level(c_lvl)
    );

    always_comb begin
        a_prev_d = a_lvl;
        b_prev_d = b_lvl;
        c_prev_d = c_lvl;
        ev       = quad_event(a_prev_q, b_prev_q, a_lvl, b_lvl);
        step_d   = (ev == QEV_STEP);
        err_d    = (ev == QEV_ERR);
        dir_d    = dir_q;
        // B low while A rises means clockwise (increment).
        if (ev == QEV_STEP) begin
            dir_d = ~b_lvl;
        end
        press_d  = c_lvl & ~c_prev_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_prev_q <= 1'b0;
            b_prev_q <= 1'b0;
            c_prev_q <= 1'b0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            press_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_prev_q <= a_prev_d;
            b_prev_q <= b_prev_d;
            c_prev_q <= c_prev_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            press_q  <= press_d;
            err_q    <= err_d;
        end
    end

    assign STEP    = step_q;
    assign DIR     = dir_q;
    assign PRESS   = press_q;
    assign ERR     = err_q;
    assign CTR_LVL = c_lvl;

endmodule

// File: tb/tb_rotary_quad_decoder.sv
// Directed bench for rotary_quad_decoder with DB_CYCLES=4, SYNC_STAGES=2.
// Inputs change on the falling edge; outputs are logged on later falling
// edges, so log bit k holds the value k cycles after the input change.
// Expected pulse position is bit 7 (2 sync + 4 debounce + 1 output).
module tb_rotary_quad_decoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    logic [31:0] step_log, dir_log, press_log, err_log, lvl_log;

    rotary_quad_decoder_if bus();

    rotary_quad_decoder #(.DB_CYCLES(4), .SYNC_STAGES(2)) dut (
        .CLK     (clk),
        .RESET   (rst),
        .ROTA    (bus.rota),
        .ROTB    (bus.rotb),
        .ROTCTR  (bus.rotctr),
        .STEP    (bus.step),
        .DIR     (bus.dir),
        .PRESS   (bus.press),
        .CTR_LVL (bus.ctr_lvl),
        .ERR     (bus.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic capture(input int n);
        step_log  = '0;
        dir_log   = '0;
        press_log = '0;
        err_log   = '0;
        lvl_log   = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            step_log[k]  = bus.step;
            dir_log[k]   = bus.dir;
            press_log[k] = bus.press;
            err_log[k]   = bus.err;
            lvl_log[k]   = bus.ctr_lvl;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.rota = 1'b0;
        bus.rotb = 1'b0;
        bus.rotctr = 1'b0;
        #12;
        n_checks++;
        if ({bus.step, bus.dir, bus.press, bus.ctr_lvl, bus.err} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000",
                     {bus.step, bus.dir, bus.press, bus.ctr_lvl, bus.err});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        capture(4);
    endtask

    task automatic test_clean_rise;
        @(negedge clk);
        bus.rotb = 1'b0;
        bus.rota = 1'b1;
        capture(12);
        n_checks++;
        if (step_log !== 32'h80) $display("FAIL rise_step: got %h want 00000080", step_log);
        else n_pass++;
        n_checks++;
        if (dir_log[7] !== 1'b1) $display("FAIL rise_dir: got %b want 1", dir_log[7]);
        else n_pass++;
        n_checks++;
        if (dir_log[12] !== 1'b1) $display("FAIL rise_dir_held: got %b want 1", dir_log[12]);
        else n_pass++;
        n_checks++;
        if (err_log !== 32'h0) $display("FAIL rise_err: got %h want 00000000", err_log);
        else n_pass++;
        bus.rota = 1'b0;
        capture(12);
        n_checks++;
        if (step_log !== 32'h0) $display("FAIL fall_step: got %h want 00000000", step_log);
        else n_pass++;
    endtask

    task automatic test_glitch;
        @(negedge clk);
        bus.rota = 1'b1;
        repeat (3) @(negedge clk);
        bus.rota = 1'b0;
        capture(12);
        n_checks++;
        if (step_log !== 32'h0) $display("FAIL glitch_step: got %h want 00000000", step_log);
        else n_pass++;
        n_checks++;
        if (err_log !== 32'h0) $display("FAIL glitch_err: got %h want 00000000", err_log);
        else n_pass++;
        n_checks++;
        if (dut.a_lvl !== 1'b0) $display("FAIL glitch_level: got %b want 0", dut.a_lvl);
        else n_pass++;
    endtask

    task automatic test_decrement;
        @(negedge clk);
        bus.rotb = 1'b1;
        capture(12);
        n_checks++;
        if ({step_log, err_log} !== 64'h0)
            $display("FAIL b_only_rise: got step %h err %h want 0 0", step_log, err_log);
        else n_pass++;
        bus.rota = 1'b1;
        capture(12);
        n_checks++;
        if (step_log !== 32'h80) $display("FAIL dec_step: got %h want 00000080", step_log);
        else n_pass++;
        n_checks++;
        if (dir_log[7] !== 1'b0) $display("FAIL dec_dir: got %b want 0", dir_log[7]);
        else n_pass++;
        bus.rota = 1'b0;
        capture(12);
        n_checks++;
        if (step_log !== 32'h0) $display("FAIL dec_fall_step: got %h want 00000000", step_log);
        else n_pass++;
        bus.rotb = 1'b0;
        capture(12);
        n_checks++;
        if ({step_log, err_log} !== 64'h0)
            $display("FAIL b_only_fall: got step %h err %h want 0 0", step_log, err_log);
        else n_pass++;
    endtask

    task automatic test_illegal;
        @(negedge clk);
        bus.rota = 1'b1;
        capture(12);
        n_checks++;
        if (step_log !== 32'h80) $display("FAIL ill_setup_step: got %h want 00000080", step_log);
        else n_pass++;
        bus.rota = 1'b0;
        capture(12);
        bus.rota = 1'b1;
        bus.rotb = 1'b1;
        capture(12);
        n_checks++;
        if (err_log !== 32'h80) $display("FAIL ill_err: got %h want 00000080", err_log);
        else n_pass++;
        n_checks++;
        if (step_log !== 32'h0) $display("FAIL ill_step: got %h want 00000000", step_log);
        else n_pass++;
        n_checks++;
        if (dir_log[12:1] !== 12'hFFF) $display("FAIL ill_dir: got %h want fff", dir_log[12:1]);
        else n_pass++;
        bus.rota = 1'b0;
        bus.rotb = 1'b0;
        capture(12);
        n_checks++;
        if ({step_log, err_log} !== {32'h0, 32'h80})
            $display("FAIL ill_fall: got step %h err %h want 0 80", step_log, err_log);
        else n_pass++;
    endtask

    task automatic test_button;
        @(negedge clk);
        bus.rotctr = 1'b1;
        capture(12);
        n_checks++;
        if (press_log !== 32'h80) $display("FAIL press_rise: got %h want 00000080", press_log);
        else n_pass++;
        n_checks++;
        if (lvl_log[12:1] !== 12'hFE0) $display("FAIL ctr_lvl_rise: got %h want fe0", lvl_log[12:1]);
        else n_pass++;
        bus.rotctr = 1'b0;
        capture(12);
        n_checks++;
        if (press_log !== 32'h0) $display("FAIL press_fall: got %h want 00000000", press_log);
        else n_pass++;
        n_checks++;
        if (lvl_log[12] !== 1'b0) $display("FAIL ctr_lvl_fall: got %b want 0", lvl_log[12]);
        else n_pass++;
        bus.rota = 1'b1;
        bus.rotctr = 1'b1;
        capture(12);
        n_checks++;
        if ({step_log, press_log} !== {32'h80, 32'h80})
            $display("FAIL step_and_press: got step %h press %h want 80 80", step_log, press_log);
        else n_pass++;
        bus.rota = 1'b0;
        bus.rotctr = 1'b0;
        capture(12);
        n_checks++;
        if ({step_log, press_log} !== 64'h0)
            $display("FAIL both_fall: got step %h press %h want 0 0", step_log, press_log);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.rotctr = 1'b1;
        capture(12);
        // DIR=1 and CTR_LVL=1 here, so the reset check sees them drop.
        bus.rota = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.step, bus.dir, bus.press, bus.ctr_lvl, bus.err} !== 5'b0)
            $display("FAIL mid_reset_outputs: got %b want 00000",
                     {bus.step, bus.dir, bus.press, bus.ctr_lvl, bus.err});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        capture(12);
        n_checks++;
        if (step_log !== 32'h80) $display("FAIL post_reset_step: got %h want 00000080", step_log);
        else n_pass++;
        n_checks++;
        if (press_log !== 32'h80) $display("FAIL post_reset_press: got %h want 00000080", press_log);
        else n_pass++;
        n_checks++;
        if (dir_log[7] !== 1'b1) $display("FAIL post_reset_dir: got %b want 1", dir_log[7]);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_decrement();
        test_illegal();
        test_button();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
